// File: rtl/seqdet_pkg_311.sv
// Shared types and constants for the round-robin serial pattern detector.
package seqdet_pkg_311;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GRANT  = 2'd1,
      ST_STREAM = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   typedef logic req_id_t;

   // Power-on pattern; the top keeps only the low PAT_W bits.
   localparam logic [7:0] PAT_RST = 8'b0000_1011;

endpackage

// File: rtl/seqdet_core_311.sv
// Serial pattern matcher: bit window, fill count, compare, Mealy hit and match counter.
// Macro SEQDET_OVERLAP_EN keeps the window history after a hit (overlapping matches).
module seqdet_core_311
   import seqdet_pkg_311::*;
#(
   parameter int PAT_W = 4,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             accept,
   input  logic             bit_in,
   input  logic [PAT_W-1:0] pattern,
   output logic             hit,
   output logic [CNT_W-1:0] count
);

   localparam int FILL_W = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  win_q, win_d, cand;
   logic [FILL_W-1:0] fill_q, fill_d;
   logic [CNT_W-1:0]  count_q, count_d;

   always_comb begin
      cand    = {win_q[PAT_W-2:0], bit_in};
      hit     = accept && (fill_q == FILL_MAX) && (cand == pattern);
      win_d   = win_q;
      fill_d  = fill_q;
      count_d = count_q;
      if (clear) begin
         win_d   = '0;
         fill_d  = '0;
         count_d = '0;
      end else if (accept) begin
         win_d = cand;
         if (fill_q != FILL_MAX) begin
            fill_d = fill_q + FILL_W'(1);
         end
         if (hit) begin
            if (count_q != '1) begin
               count_d = count_q + CNT_W'(1);
            end
`ifdef SEQDET_OVERLAP_EN
            fill_d = fill_d;
`else
            // A match consumes its bits: the next match must be built from fresh bits.
            fill_d = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_q   <= '0;
         fill_q  <= '0;
         count_q <= '0;
      end else begin
         win_q   <= win_d;
         fill_q  <= fill_d;
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/seqdet_arb_311.sv
// Two-requester round-robin frame arbiter feeding a serial pattern detector.
// Macro SEQDET_OVERLAP_EN (in seqdet_core_311) selects overlapping detection.
module seqdet_arb_311
   import seqdet_pkg_311::*;
#(
   parameter int PAT_W     = 4,
   parameter int FRAME_LEN = 16,
   parameter int CNT_W     = 5
) (
   input  logic             clk_311,
   input  logic             rst_311,
   input  logic             cfg_we_311,
   input  logic [PAT_W-1:0] cfg_pat_311,
   output logic             cfg_busy_311,
   input  logic [1:0]       req_311,
   input  logic [1:0]       bit_vld_311,
   input  logic [1:0]       bit_311,
   output logic [1:0]       gnt_311,
   output logic             hit_311,
   output logic             done_311,
   output logic             done_id_311,
   output logic             abort_311,
   output logic [CNT_W-1:0] match_cnt_311
);

   localparam int ACC_W = $clog2(FRAME_LEN + 1);
   localparam logic [ACC_W-1:0] LAST_BIT = ACC_W'(FRAME_LEN - 1);

   state_e           state_q, state_d;
   req_id_t          id_q, id_d, ptr_q, ptr_d, winner;
   logic [PAT_W-1:0] pat_q, pat_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             abort_q, abort_d, pend_q, pend_d;
   logic             clear, accept, sel_bit;

   always_comb begin
      state_d      = state_q;
      id_d         = id_q;
      ptr_d        = ptr_q;
      pat_d        = pat_q;
      acc_d        = acc_q;
      abort_d      = abort_q;
      pend_d       = pend_q;
      clear        = 1'b0;
      accept       = 1'b0;
      gnt_311      = 2'b00;
      cfg_busy_311 = 1'b1;
      done_311     = 1'b0;
      done_id_311  = 1'b0;
      abort_311    = 1'b0;
      sel_bit      = bit_311[id_q];
      winner       = (req_311 == 2'b11) ? ptr_q : req_311[1];
      case (state_q)
         ST_IDLE: begin
            cfg_busy_311 = 1'b0;
            if (cfg_we_311) begin
               pat_d = cfg_pat_311;
            end
            if (|req_311) begin
               id_d    = winner;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            clear   = 1'b1;
            acc_d   = '0;
            pend_d  = 1'b0;
            abort_d = 1'b0;
            state_d = ST_STREAM;
         end
         ST_STREAM: begin
            // Once the requester has dropped, the grant is withdrawn and the frame closes.
            if (!pend_q) begin
               gnt_311[id_q] = 1'b1;
               accept        = bit_vld_311[id_q];
            end
            if (accept) begin
               acc_d = acc_q + ACC_W'(1);
               if (acc_q == LAST_BIT) begin
                  abort_d = 1'b0;
                  state_d = ST_DONE;
               end else if (!req_311[id_q]) begin
                  pend_d = 1'b1;
               end
            end else if (pend_q || !req_311[id_q]) begin
               abort_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            done_311    = 1'b1;
            done_id_311 = id_q;
            abort_311   = abort_q;
            ptr_d       = ~id_q;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_311 or negedge rst_311) begin
      if (!rst_311) begin
         state_q <= ST_IDLE;
         id_q    <= 1'b0;
         ptr_q   <= 1'b0;
         pat_q   <= PAT_RST[PAT_W-1:0];
         acc_q   <= '0;
         abort_q <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         ptr_q   <= ptr_d;
         pat_q   <= pat_d;
         acc_q   <= acc_d;
         abort_q <= abort_d;
         pend_q  <= pend_d;
      end
   end

   seqdet_core_311 #(
      .PAT_W (PAT_W),
      .CNT_W (CNT_W)
   ) u_core (
      .clk     (clk_311),
      .rst_n   (rst_311),
      .clear   (clear),
      .accept  (accept),
      .bit_in  (sel_bit),
      .pattern (pat_q),
      .hit     (hit_311),
      .count   (match_cnt_311)
   );

endmodule

// File: tb/tb_seqdet_arb_311.sv
// Directed scoreboard bench for seqdet_arb_311: arbitration, detection, abort, config and reset.
module tb_seqdet_arb_311;

   localparam int PW = 4;
   localparam int FL = 16;
   localparam int CW = 5;
`ifdef SEQDET_OVERLAP_EN
   localparam bit OVL = 1'b1;
`else
   localparam bit OVL = 1'b0;
`endif

   logic          clk_311 = 1'b0;
   logic          rst_311;
   logic          cfg_we_311;
   logic [PW-1:0] cfg_pat_311;
   logic          cfg_busy_311;
   logic [1:0]    req_311, bit_vld_311, bit_311, gnt_311;
   logic          hit_311, done_311, done_id_311, abort_311;
   logic [CW-1:0] match_cnt_311;

   typedef struct {
      logic          id;
      logic          abort;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   logic [PW-1:0] m_pat;
   int            errors = 0;
   int            checks = 0;

   seqdet_arb_311 #(.PAT_W(PW), .FRAME_LEN(FL), .CNT_W(CW)) dut (
      .clk_311       (clk_311),
      .rst_311       (rst_311),
      .cfg_we_311    (cfg_we_311),
      .cfg_pat_311   (cfg_pat_311),
      .cfg_busy_311  (cfg_busy_311),
      .req_311       (req_311),
      .bit_vld_311   (bit_vld_311),
      .bit_311       (bit_311),
      .gnt_311       (gnt_311),
      .hit_311       (hit_311),
      .done_311      (done_311),
      .done_id_311   (done_id_311),
      .abort_311     (abort_311),
      .match_cnt_311 (match_cnt_311)
   );

   always #5 clk_311 = ~clk_311;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Request a frame, check the grant, stream bits against a reference model, queue the expected result.
   task automatic applyStimulus(input logic [1:0] req_val, input int rid, input logic [15:0] bits,
                                input int nbits, input logic [1:0] req_after, input bit aborts,
                                input bit push, input logic [1:0] exp_gnt, input int cfg_at);
      logic [PW-1:0] mwin;
      int            mfill;
      logic [CW-1:0] mcnt;
      logic          b, eh;
      int            wait_n;
      exp_t          e;
      req_311 = req_val;
      wait_n  = 0;
      while (gnt_311 == 2'b00 && wait_n < 10) begin
         @(negedge clk_311);
         wait_n++;
      end
      checkOutput("gnt_onehot", gnt_311, exp_gnt);
      checkOutput("grant_latency", wait_n, 2);
      mwin  = '0;
      mfill = 0;
      mcnt  = '0;
      for (int i = 0; i < nbits; i++) begin
         b              = bits[15-i];
         bit_vld_311    = 2'b11;
         bit_311[rid]   = b;
         bit_311[1-rid] = ~b;
         cfg_we_311     = (i == cfg_at);
         cfg_pat_311    = 4'b1111;
         #1;
         if (i == cfg_at) checkOutput("busy_in_stream", cfg_busy_311, 1);
         eh = (mfill >= PW - 1) && ({mwin[PW-2:0], b} == m_pat);
         checkOutput("hit", hit_311, eh);
         if (eh && mcnt != '1) mcnt++;
         mwin = {mwin[PW-2:0], b};
         if (eh && !OVL) mfill = 0;
         else if (mfill < PW - 1) mfill++;
         @(negedge clk_311);
      end
      cfg_we_311  = 1'b0;
      bit_vld_311 = 2'b00;
      bit_311     = 2'b00;
      req_311     = req_after;
      if (push) begin
         e.id    = rid[0];
         e.abort = aborts;
         e.cnt   = mcnt;
         sb.push_back(e);
      end
   endtask

   task automatic waitDone();
      int   n;
      exp_t e;
      n = 0;
      while (!done_311 && n < 40) begin
         @(negedge clk_311);
         n++;
      end
      checkOutput("done_seen", done_311, 1);
      checkOutput("sb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checkOutput("done_id", done_id_311, e.id);
         checkOutput("abort", abort_311, e.abort);
         checkOutput("match_cnt", match_cnt_311, e.cnt);
         @(negedge clk_311);
         checkOutput("done_pulse", done_311, 0);
         checkOutput("cnt_hold", match_cnt_311, e.cnt);
      end
   endtask

   initial begin
      rst_311     = 1'b1;
      cfg_we_311  = 1'b0;
      cfg_pat_311 = '0;
      req_311     = 2'b00;
      bit_vld_311 = 2'b00;
      bit_311     = 2'b00;
      m_pat       = 4'b1011;
      #1 rst_311  = 1'b0;
      #2;
      checkOutput("rst_gnt", gnt_311, 0);
      checkOutput("rst_done", done_311, 0);
      checkOutput("rst_busy", cfg_busy_311, 0);
      checkOutput("rst_cnt", match_cnt_311, 0);
      checkOutput("rst_abort", abort_311, 0);
      @(negedge clk_311);
      rst_311 = 1'b1;

      // Default pattern frame, with an ignored write while streaming.
      applyStimulus(2'b01, 0, 16'b1011011000000000, 16, 2'b00, 0, 1, 2'b01, 1);
      waitDone();
      checkOutput("cnt_1011_frame", match_cnt_311, OVL ? 2 : 1);

      // Requester 1 drops after five bits.
      applyStimulus(2'b10, 1, 16'b1011000000000000, 5, 2'b00, 1, 1, 2'b10, -1);
      waitDone();
      checkOutput("cnt_abort_frame", match_cnt_311, 1);

      // Both requesting back to back: round-robin order.
      applyStimulus(2'b11, 0, 16'b1011011000000000, 16, 2'b11, 0, 1, 2'b01, -1);
      waitDone();
      applyStimulus(2'b11, 1, 16'h0000, 16, 2'b11, 0, 1, 2'b10, -1);
      waitDone();
      applyStimulus(2'b11, 0, 16'h0000, 16, 2'b00, 0, 1, 2'b01, -1);
      waitDone();

      // Pattern write in IDLE, then all ones.
      cfg_we_311  = 1'b1;
      cfg_pat_311 = 4'b1111;
      #1;
      checkOutput("busy_idle", cfg_busy_311, 0);
      @(negedge clk_311);
      cfg_we_311 = 1'b0;
      m_pat      = 4'b1111;
      applyStimulus(2'b01, 0, 16'hFFFF, 16, 2'b00, 0, 1, 2'b01, -1);
      waitDone();
      checkOutput("cnt_ones_frame", match_cnt_311, OVL ? 13 : 4);

      // Write and request in the same IDLE cycle.
      cfg_we_311  = 1'b1;
      cfg_pat_311 = 4'b0110;
      m_pat       = 4'b0110;
      applyStimulus(2'b01, 0, 16'b0110011001100110, 16, 2'b00, 0, 1, 2'b01, -1);
      waitDone();

      // Reset after seven bits of a frame.
      applyStimulus(2'b01, 0, 16'b1011011000000000, 7, 2'b01, 0, 0, 2'b01, -1);
      #2 rst_311 = 1'b0;
      #1;
      checkOutput("mid_rst_gnt", gnt_311, 0);
      checkOutput("mid_rst_cnt", match_cnt_311, 0);
      checkOutput("mid_rst_done", done_311, 0);
      checkOutput("mid_rst_busy", cfg_busy_311, 0);
      @(negedge clk_311);
      rst_311 = 1'b1;
      req_311 = 2'b00;
      m_pat   = 4'b1011;
      @(negedge clk_311);
      checkOutput("post_rst_done", done_311, 0);

      applyStimulus(2'b11, 0, 16'b1011011000000000, 16, 2'b00, 0, 1, 2'b01, -1);
      waitDone();
      checkOutput("cnt_after_rst", match_cnt_311, OVL ? 2 : 1);
      checkOutput("sb_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
